// File: rtl/sweep_sequencer.sv
// Two-axis servo sweep: scans H then V, returns to the brightest position on each axis.
// Optional ABORT input is enabled by defining SWEEP_SEQUENCER_ABORT_EN.
module sweep_sequencer #(
  parameter int H_STEPS      = 16,
  parameter int V_STEPS      = 8,
  parameter int SETTLE_TICKS = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        TICK,
  input  logic        START,
  input  logic [11:0] V_IN,
  input  logic        V_VALID,
`ifdef SWEEP_SEQUENCER_ABORT_EN
  input  logic        ABORT,
`endif
  output logic        STEP_L,
  output logic        STEP_R,
  output logic        STEP_U,
  output logic        STEP_D,
  output logic [11:0] MAX_V,
  output logic [7:0]  BEST_H,
  output logic [7:0]  BEST_V,
  output logic        BUSY,
  output logic        DONE,
  output logic [2:0]  STAT
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HSWEEP = 3'd1;
  localparam logic [2:0] S_HRET   = 3'd2;
  localparam logic [2:0] S_VSWEEP = 3'd3;
  localparam logic [2:0] S_VRET   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [7:0] H_LAST    = 8'(H_STEPS - 1);
  localparam logic [7:0] V_LAST    = 8'(V_STEPS - 1);
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_TICKS);

  logic [2:0]  r_state;
  logic        r_busy;
  logic        r_done;
  logic [11:0] r_v_lat;
  logic [11:0] r_max_v;
  logic [7:0]  r_best_h;
  logic [7:0]  r_best_v;
  logic [7:0]  r_h_pos;
  logic [7:0]  r_v_pos;
  logic [3:0]  r_settle;
  logic        r_step_l;
  logic        r_step_r;
  logic        r_step_u;
  logic        r_step_d;

  logic [2:0]  w_state_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;
  logic        w_step_l_nxt;
  logic        w_step_r_nxt;
  logic        w_step_u_nxt;
  logic        w_step_d_nxt;
  logic        w_abort;
  logic        w_sample;
  logic        w_h_more;
  logic        w_v_more;
  logic        w_new_max;

`ifdef SWEEP_SEQUENCER_ABORT_EN
  assign w_abort = ABORT;
`else
  assign w_abort = 1'b0;
`endif

  // A sample TICK is one that arrives after the settle wait has fully elapsed.
  assign w_sample  = TICK && (r_settle == 4'd0);
  assign w_h_more  = (r_h_pos < H_LAST);
  assign w_v_more  = (r_v_pos < V_LAST);
  assign w_new_max = (r_v_lat > r_max_v);

  // State register with registered status flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state decision.
  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (START) w_state_nxt = S_HSWEEP;
          else       w_state_nxt = r_state;
        end
        S_HSWEEP: begin
          if (w_sample && !w_h_more) w_state_nxt = S_HRET;
          else                       w_state_nxt = S_HSWEEP;
        end
        S_HRET: begin
          if (TICK && (r_h_pos == r_best_h)) w_state_nxt = S_VSWEEP;
          else                               w_state_nxt = S_HRET;
        end
        S_VSWEEP: begin
          if (w_sample && !w_v_more) w_state_nxt = S_VRET;
          else                       w_state_nxt = S_VSWEEP;
        end
        S_VRET: begin
          if (TICK && (r_v_pos == r_best_v)) w_state_nxt = S_DONE;
          else                               w_state_nxt = S_VRET;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output decode: status flags follow the next state, step pulses follow the deciding TICK.
  always_comb begin
    w_busy_nxt   = (w_state_nxt >= S_HSWEEP) && (w_state_nxt <= S_VRET);
    w_done_nxt   = (w_state_nxt == S_DONE);
    w_step_l_nxt = 1'b0;
    w_step_r_nxt = 1'b0;
    w_step_u_nxt = 1'b0;
    w_step_d_nxt = 1'b0;
    if (w_abort) begin
      w_step_l_nxt = 1'b0;
    end else begin
      case (r_state)
        S_HSWEEP: w_step_r_nxt = w_sample && w_h_more;
        S_HRET:   w_step_l_nxt = TICK && (r_h_pos != r_best_h);
        S_VSWEEP: w_step_u_nxt = w_sample && w_v_more;
        S_VRET:   w_step_d_nxt = TICK && (r_v_pos != r_best_v);
        default:  w_step_l_nxt = 1'b0;
      endcase
    end
  end

  // Datapath: voltage latch, peak tracking, position counters and settle timer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_v_lat  <= 12'd0;
      r_max_v  <= 12'd0;
      r_best_h <= 8'd0;
      r_best_v <= 8'd0;
      r_h_pos  <= 8'd0;
      r_v_pos  <= 8'd0;
      r_settle <= 4'd0;
      r_step_l <= 1'b0;
      r_step_r <= 1'b0;
      r_step_u <= 1'b0;
      r_step_d <= 1'b0;
    end else begin
      if (V_VALID) r_v_lat <= V_IN;
      r_step_l <= w_step_l_nxt;
      r_step_r <= w_step_r_nxt;
      r_step_u <= w_step_u_nxt;
      r_step_d <= w_step_d_nxt;
      if (!w_abort) begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (START) begin
              r_max_v  <= 12'd0;
              r_best_h <= 8'd0;
              r_best_v <= 8'd0;
              r_h_pos  <= 8'd0;
              r_v_pos  <= 8'd0;
              r_settle <= SETTLE_LD;
            end
          end
          S_HSWEEP, S_VSWEEP: begin
            if (TICK && (r_settle != 4'd0)) begin
              r_settle <= r_settle - 4'd1;
            end else if (w_sample) begin
              // Strict compare: the first position to reach a value keeps it.
              if (w_new_max) begin
                r_max_v <= r_v_lat;
                if (r_state == S_HSWEEP) r_best_h <= r_h_pos;
                else                     r_best_v <= r_v_pos;
              end
              if (w_step_r_nxt) begin
                r_h_pos  <= r_h_pos + 8'd1;
                r_settle <= SETTLE_LD;
              end
              if (w_step_u_nxt) begin
                r_v_pos  <= r_v_pos + 8'd1;
                r_settle <= SETTLE_LD;
              end
            end
          end
          S_HRET: begin
            if (w_step_l_nxt)  r_h_pos  <= r_h_pos - 8'd1;
            else if (TICK)     r_settle <= SETTLE_LD;
          end
          S_VRET: begin
            if (w_step_d_nxt)  r_v_pos  <= r_v_pos - 8'd1;
          end
          default: r_settle <= r_settle;
        endcase
      end
    end
  end

  assign STEP_L = r_step_l;
  assign STEP_R = r_step_r;
  assign STEP_U = r_step_u;
  assign STEP_D = r_step_d;
  assign MAX_V  = r_max_v;
  assign BEST_H = r_best_h;
  assign BEST_V = r_best_v;
  assign BUSY   = r_busy;
  assign DONE   = r_done;
  assign STAT   = r_state;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Bench for sweep_sequencer: two instances (settle 0 and settle 2) share stimulus and are
// each compared every cycle against a behavioural model, plus directed literal checks.
module tb_sweep_sequencer;
  localparam int HS = 4;
  localparam int VS = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        TICK = 1'b0;
  logic        START = 1'b0;
  logic        V_VALID = 1'b0;
  logic [11:0] V_IN = 12'd0;
  logic        ab_s;
`ifdef SWEEP_SEQUENCER_ABORT_EN
  logic        ABORT = 1'b0;
  assign ab_s = ABORT;
`else
  assign ab_s = 1'b0;
`endif

  logic        l0, r0, u0, d0, busy0, done0;
  logic [11:0] mx0;
  logic [7:0]  bh0, bv0;
  logic [2:0]  stat0;
  logic        l2, r2, u2, d2, busy2, done2;
  logic [11:0] mx2;
  logic [7:0]  bh2, bv2;
  logic [2:0]  stat2;

  always #5 CLK = ~CLK;

  sweep_sequencer #(.H_STEPS(HS), .V_STEPS(VS), .SETTLE_TICKS(0)) u_dut0 (
    .CLK(CLK), .RST(RST), .TICK(TICK), .START(START), .V_IN(V_IN), .V_VALID(V_VALID),
`ifdef SWEEP_SEQUENCER_ABORT_EN
    .ABORT(ABORT),
`endif
    .STEP_L(l0), .STEP_R(r0), .STEP_U(u0), .STEP_D(d0), .MAX_V(mx0), .BEST_H(bh0),
    .BEST_V(bv0), .BUSY(busy0), .DONE(done0), .STAT(stat0));

  sweep_sequencer #(.H_STEPS(HS), .V_STEPS(VS), .SETTLE_TICKS(2)) u_dut2 (
    .CLK(CLK), .RST(RST), .TICK(TICK), .START(START), .V_IN(V_IN), .V_VALID(V_VALID),
`ifdef SWEEP_SEQUENCER_ABORT_EN
    .ABORT(ABORT),
`endif
    .STEP_L(l2), .STEP_R(r2), .STEP_U(u2), .STEP_D(d2), .MAX_V(mx2), .BEST_H(bh2),
    .BEST_V(bv2), .BUSY(busy2), .DONE(done2), .STAT(stat2));

  typedef struct packed {
    int st; int hp; int vp; int bh; int bv; int mx; int cnt; int vlat;
    bit sl; bit sr; bit su; bit sd;
  } mdl_t;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Sweep model: the panel position moves one step per pulse; peak is found by strict compare.
  function automatic mdl_t mstep(input mdl_t m, input int settle, input bit rst, input bit tick,
                                 input bit start, input bit vv, input int vin, input bit ab);
    mdl_t n = m;
    n.sl = 0; n.sr = 0; n.su = 0; n.sd = 0;
    if (rst) return '0;
    if (vv) n.vlat = vin;
    if (ab) begin n.st = 0; return n; end
    if (m.st == 0 || m.st == 5) begin
      if (start) begin
        n.st = 1; n.mx = 0; n.bh = 0; n.bv = 0; n.hp = 0; n.vp = 0; n.cnt = settle;
      end
    end else if ((m.st == 1 || m.st == 3) && tick) begin
      if (m.cnt > 0) n.cnt = m.cnt - 1;
      else begin
        if (m.vlat > m.mx) begin
          n.mx = m.vlat;
          if (m.st == 1) n.bh = m.hp; else n.bv = m.vp;
        end
        if (m.st == 1 && m.hp < HS - 1) begin n.hp = m.hp + 1; n.sr = 1; n.cnt = settle; end
        else if (m.st == 3 && m.vp < VS - 1) begin n.vp = m.vp + 1; n.su = 1; n.cnt = settle; end
        else n.st = m.st + 1;
      end
    end else if (m.st == 2 && tick) begin
      if (m.hp > m.bh) begin n.hp = m.hp - 1; n.sl = 1; end
      else begin n.st = 3; n.cnt = settle; end
    end else if (m.st == 4 && tick) begin
      if (m.vp > m.bv) begin n.vp = m.vp - 1; n.sd = 1; end
      else n.st = 5;
    end
    return n;
  endfunction

  mdl_t m0 = '0;
  mdl_t m2 = '0;
  bit   chk_en = 1'b0;

  always @(posedge CLK) begin
    m0 <= mstep(m0, 0, RST, TICK, START, V_VALID, int'(V_IN), ab_s);
    m2 <= mstep(m2, 2, RST, TICK, START, V_VALID, int'(V_IN), ab_s);
    if (RST) chk_en <= 1'b1;
  end

  task automatic cmp_dut(input string tag, input mdl_t m, input logic [2:0] stat,
                         input logic busy, input logic done, input logic sl, input logic sr,
                         input logic su, input logic sd, input logic [11:0] mx,
                         input logic [7:0] bh, input logic [7:0] bv);
    check({tag, " STAT"}, stat, m.st);
    check({tag, " BUSY"}, busy, (m.st >= 1 && m.st <= 4) ? 1 : 0);
    check({tag, " DONE"}, done, (m.st == 5) ? 1 : 0);
    check({tag, " STEP_L"}, sl, m.sl);
    check({tag, " STEP_R"}, sr, m.sr);
    check({tag, " STEP_U"}, su, m.su);
    check({tag, " STEP_D"}, sd, m.sd);
    check({tag, " MAX_V"}, mx, m.mx);
    check({tag, " BEST_H"}, bh, m.bh);
    check({tag, " BEST_V"}, bv, m.bv);
    check({tag, " one step"}, ((32'(sl) + 32'(sr) + 32'(su) + 32'(sd)) <= 32'd1) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Per-cycle comparison of both instances against their models.
  always @(negedge CLK) begin
    if (chk_en) begin
      cmp_dut("d0", m0, stat0, busy0, done0, l0, r0, u0, d0, mx0, bh0, bv0);
      cmp_dut("d2", m2, stat2, busy2, done2, l2, r2, u2, d2, mx2, bh2, bv2);
    end
  end

  int n_l0 = 0, n_r0 = 0, n_u0 = 0, n_d0 = 0;
  always @(negedge CLK) begin
    if (l0 === 1'b1) n_l0++;
    if (r0 === 1'b1) n_r0++;
    if (u0 === 1'b1) n_u0++;
    if (d0 === 1'b1) n_d0++;
  end

  task automatic cyc();
    @(negedge CLK);
    #1;
  endtask

  task automatic do_tick();
    TICK = 1'b1; cyc(); TICK = 1'b0; cyc();
  endtask

  task automatic do_sample(input logic [11:0] v);
    V_IN = v; V_VALID = 1'b1; cyc(); V_VALID = 1'b0;
    do_tick();
  endtask

  task automatic do_start();
    START = 1'b1; cyc(); START = 1'b0; cyc();
  endtask

  task automatic do_reset();
    RST = 1'b1; cyc(); RST = 1'b0; cyc();
  endtask

  int bl, br, bu, bd;

  initial begin
    do_reset();
    check("reset STAT", stat0, 0);
    check("reset BUSY", busy0, 0);
    do_start();
    check("start STAT", stat0, 1);

    // Horizontal 100,300,200,50 then vertical 250,400,400.
    br = n_r0; bl = n_l0;
    do_sample(12'd100); do_sample(12'd300); do_sample(12'd200); do_sample(12'd50);
    check("h STEP_R count", n_r0 - br, 3);
    check("h STAT", stat0, 2);
    check("h MAX_V", mx0, 300);
    check("h BEST_H", bh0, 1);
    check("h model MAX_V", m0.mx, 300);
    for (int i = 0; i < 3; i++) do_tick();
    check("h STEP_L count", n_l0 - bl, 2);
    check("h->v STAT", stat0, 3);
    bu = n_u0; bd = n_d0;
    do_sample(12'd250); do_sample(12'd400); do_sample(12'd400);
    check("v STEP_U count", n_u0 - bu, 2);
    check("v MAX_V", mx0, 400);
    check("v BEST_V tie", bv0, 1);
    check("v model BEST_V", m0.bv, 1);
    do_tick(); do_tick();
    check("v STEP_D count", n_d0 - bd, 1);
    check("end STAT", stat0, 5);
    check("end DONE", done0, 1);

    // All-zero sweep restarted from DONE.
    do_start();
    check("zero restart BUSY", busy0, 1);
    for (int i = 0; i < HS; i++) do_sample(12'd0);
    for (int i = 0; i < HS; i++) do_tick();
    for (int i = 0; i < VS; i++) do_sample(12'd0);
    for (int i = 0; i < VS; i++) do_tick();
    check("zero STAT", stat0, 5);
    check("zero BEST_H", bh0, 0);
    check("zero BEST_V", bv0, 0);
    check("zero MAX_V", mx0, 0);

    // TICK with V_VALID in the same cycle compares the previously latched voltage.
    do_start();
    do_sample(12'd500);
    V_IN = 12'd100; V_VALID = 1'b1; cyc(); V_VALID = 1'b0; cyc();
    V_IN = 12'd700; V_VALID = 1'b1; TICK = 1'b1; cyc(); V_VALID = 1'b0; TICK = 1'b0; cyc();
    check("same-cycle MAX_V", mx0, 500);
    do_tick();
    check("next MAX_V", mx0, 700);
    check("next BEST_H", bh0, 2);

    // Reset mid-sweep after the second STEP_R; START while busy is ignored.
    do_reset();
    do_start();
    do_sample(12'd10); do_sample(12'd20);
    do_start();
    check("busy START STAT", stat0, 1);
    check("busy START MAX_V", mx0, 20);
    RST = 1'b1; cyc(); RST = 1'b0;
    check("rst STAT", stat0, 0);
    check("rst MAX_V", mx0, 0);
    check("rst BEST_H", bh0, 0);
    check("rst BUSY", busy0, 0);
    check("rst STEP_R", r0, 0);
    cyc();

    // Settle of 2: every third TICK is a sample TICK producing STEP_R.
    do_start();
    for (int k = 1; k <= 9; k++) begin
      TICK = 1'b1; cyc(); TICK = 1'b0;
      check($sformatf("settle STEP_R tick %0d", k), r2, (k % 3 == 0) ? 1 : 0);
      cyc();
    end

`ifdef SWEEP_SEQUENCER_ABORT_EN
    do_reset();
    do_start();
    do_sample(12'd10); do_sample(12'd20); do_sample(12'd30); do_sample(12'd40);
    do_tick();
    do_sample(12'd5);
    check("abort pre STAT", stat0, 3);
    ABORT = 1'b1; cyc(); ABORT = 1'b0;
    check("abort STAT", stat0, 0);
    check("abort MAX_V", mx0, 40);
    check("abort BEST_H", bh0, 3);
    bu = n_u0; br = n_r0; bl = n_l0; bd = n_d0;
    for (int i = 0; i < 3; i++) do_tick();
    check("abort no steps", (n_u0 - bu) + (n_r0 - br) + (n_l0 - bl) + (n_d0 - bd), 0);
`endif

    do_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
